// File: rtl/hermes_fetch_pkg.sv
// rtl/hermes_fetch_pkg.sv - shared types and constants for the instruction fetch block
package hermes_fetch_pkg;

  typedef logic [63:0] word_t;

  localparam int unsigned INSTR_BYTES = 8;

  typedef enum logic [2:0] {
    IDLE,
    REQUEST,
    WAIT,
    DELIVER,
    DONE
  } fetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Force an address onto an instruction boundary
  function automatic word_t align_pc(input word_t addr);
    return addr & ~word_t'(INSTR_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - two-entry {pc, instr} prefetch buffer with synchronous flush
module fetch_fifo
  import hermes_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         i_reset_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_push_data,
  input  logic         i_pop,
  output fetch_entry_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  fetch_entry_t r_mem [2];
  logic         r_rd_ptr;
  logic         r_wr_ptr;
  logic [1:0]   r_count;
  logic         w_push_ok;
  logic         w_pop_ok;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // Storage array; validity is tracked by r_count, so no reset is needed here
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
  end

  // Pointers and occupancy; a flush empties the buffer in one cycle
  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch FSM; PREFETCH_BUF_EN swaps the deliver register for a 2-entry FIFO
module instruction_fetch
  import hermes_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = 64'h0,
  parameter int          NumInstructions = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [63:0] instructionAddress,
  output logic        read_request,
  input  logic [63:0] instruction_in,
  input  logic        readReady,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        stall,
  output logic        fetch_valid,
  output logic [63:0] fetch_instruction,
  output logic [63:0] fetch_pc,
  output logic        done
);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  word_t        r_pc;
  word_t        w_pc_inc;
  logic         w_last;
  logic         w_redirect;

  assign w_pc_inc   = r_pc + word_t'(INSTR_BYTES);
  assign w_last     = (w_pc_inc >> 3) >= word_t'(NumInstructions);
  assign w_redirect = branch_taken && (r_state != IDLE);

`ifdef PREFETCH_BUF_EN
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic         w_push;
  logic         w_pop;

  assign w_push = (r_state == WAIT) && readReady && !branch_taken;
  assign w_pop  = !w_empty && !stall && !branch_taken;

  fetch_fifo u_fetch_fifo (
    .clk         (clk),
    .i_reset_n   (reset),
    .i_flush     (w_redirect),
    .i_push      (w_push),
    .i_push_data ('{pc: r_pc, instr: instruction_in}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );
`else
  word_t r_cap_pc;
  word_t r_cap_instr;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next state and state-decoded outputs; a redirect overrides every other transition
  always_comb begin
    w_state_next       = r_state;
    read_request       = 1'b0;
    instructionAddress = '0;
    fetch_valid        = 1'b0;
    fetch_instruction  = '0;
    fetch_pc           = '0;
    done               = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_next = REQUEST;
      end
      REQUEST: begin
`ifdef PREFETCH_BUF_EN
        if (!w_full) begin
          read_request       = 1'b1;
          instructionAddress = r_pc;
          w_state_next       = WAIT;
        end
`else
        read_request       = 1'b1;
        instructionAddress = r_pc;
        w_state_next       = WAIT;
`endif
      end
      WAIT: begin
        read_request       = 1'b1;
        instructionAddress = r_pc;
`ifdef PREFETCH_BUF_EN
        if (readReady) w_state_next = w_last ? DONE : REQUEST;
`else
        if (readReady) w_state_next = DELIVER;
`endif
      end
      DELIVER: begin
`ifdef PREFETCH_BUF_EN
        w_state_next = REQUEST;
`else
        fetch_valid       = 1'b1;
        fetch_instruction = r_cap_instr;
        fetch_pc          = r_cap_pc;
        if (!stall) w_state_next = w_last ? DONE : REQUEST;
`endif
      end
      DONE: begin
`ifdef PREFETCH_BUF_EN
        done = w_empty;
`else
        done = 1'b1;
`endif
      end
      default: w_state_next = IDLE;
    endcase
`ifdef PREFETCH_BUF_EN
    fetch_valid       = !w_empty;
    fetch_instruction = w_empty ? '0 : w_head.instr;
    fetch_pc          = w_empty ? '0 : w_head.pc;
`endif
    if (w_redirect) w_state_next = REQUEST;
  end

  // PC and captured word; a redirect discards whatever was captured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
`ifndef PREFETCH_BUF_EN
      r_cap_pc    <= '0;
      r_cap_instr <= '0;
`endif
    end else if (r_state == IDLE) begin
      if (start) r_pc <= RESET_PC;
    end else if (branch_taken) begin
      r_pc <= align_pc(branch_target);
`ifndef PREFETCH_BUF_EN
      r_cap_pc    <= '0;
      r_cap_instr <= '0;
`endif
    end else begin
`ifdef PREFETCH_BUF_EN
      if (r_state == WAIT && readReady) r_pc <= w_pc_inc;
`else
      if (r_state == WAIT && readReady) begin
        r_cap_pc    <= r_pc;
        r_cap_instr <= instruction_in;
      end
      if (r_state == DELIVER && !stall) r_pc <= w_pc_inc;
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] instructionAddress;
  logic        read_request;
  logic [63:0] instruction_in;
  logic        readReady;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        stall;
  logic        fetch_valid;
  logic [63:0] fetch_instruction;
  logic [63:0] fetch_pc;
  logic        done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(64'h0), .NumInstructions(5)) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .instructionAddress (instructionAddress),
    .read_request       (read_request),
    .instruction_in     (instruction_in),
    .readReady          (readReady),
    .branch_taken       (branch_taken),
    .branch_target      (branch_target),
    .stall              (stall),
    .fetch_valid        (fetch_valid),
    .fetch_instruction  (fetch_instruction),
    .fetch_pc           (fetch_pc),
    .done               (done)
  );

  // Memory model: each word is tagged with its own address
  function automatic logic [63:0] mem_word(input logic [63:0] a);
    return 64'hA5A5_0000_0000_0000 ^ a;
  endfunction

  assign instruction_in = mem_word(instructionAddress);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the DUT in REQUEST at pc 0
  task automatic restart();
    reset = 1'b0;
    step();
    reset = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    step();
    total++; if (read_request !== 1'b0) begin bad++; $display("FAIL rst_rr got %b want 0", read_request); end
    total++; if (instructionAddress !== 64'h0) begin bad++; $display("FAIL rst_addr got %h want 0", instructionAddress); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got %b want 0", fetch_valid); end
    total++; if (fetch_pc !== 64'h0) begin bad++; $display("FAIL rst_fpc got %h want 0", fetch_pc); end
    total++; if (fetch_instruction !== 64'h0) begin bad++; $display("FAIL rst_fi got %h want 0", fetch_instruction); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b want 0", done); end
    reset = 1'b1;
    step();
    step();
    total++; if (read_request !== 1'b0) begin bad++; $display("FAIL idle_hold_rr got %b want 0", read_request); end
  endtask

  task automatic test_sequential();
    logic [63:0] exp;
    readReady = 1'b1;
    restart();
    for (int k = 0; k < 5; k++) begin
      exp = 64'(k * 8);
      total++; if (read_request !== 1'b1) begin bad++; $display("FAIL seq_req_rr k=%0d got %b want 1", k, read_request); end
      total++; if (instructionAddress !== exp) begin bad++; $display("FAIL seq_req_addr k=%0d got %h want %h", k, instructionAddress, exp); end
      step();
      total++; if (instructionAddress !== exp) begin bad++; $display("FAIL seq_wait_addr k=%0d got %h want %h", k, instructionAddress, exp); end
      total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL seq_wait_fv k=%0d got %b want 0", k, fetch_valid); end
      step();
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL seq_fv k=%0d got %b want 1", k, fetch_valid); end
      total++; if (fetch_pc !== exp) begin bad++; $display("FAIL seq_fpc k=%0d got %h want %h", k, fetch_pc, exp); end
      total++; if (fetch_instruction !== mem_word(exp)) begin bad++; $display("FAIL seq_fi k=%0d got %h want %h", k, fetch_instruction, mem_word(exp)); end
      step();
    end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL seq_done got %b want 1", done); end
    total++; if (read_request !== 1'b0) begin bad++; $display("FAIL seq_done_rr got %b want 0", read_request); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL seq_done_fv got %b want 0", fetch_valid); end
  endtask

  task automatic test_stall();
    readReady = 1'b1;
    restart();
    step(); step(); step(); step();
    stall = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL stall_fv i=%0d got %b want 1", i, fetch_valid); end
      total++; if (fetch_pc !== 64'h8) begin bad++; $display("FAIL stall_fpc i=%0d got %h want 8", i, fetch_pc); end
      total++; if (fetch_instruction !== mem_word(64'h8)) begin bad++; $display("FAIL stall_fi i=%0d got %h want %h", i, fetch_instruction, mem_word(64'h8)); end
      total++; if (read_request !== 1'b0) begin bad++; $display("FAIL stall_rr i=%0d got %b want 0", i, read_request); end
      step();
    end
    stall = 1'b0;
    step();
    total++; if (read_request !== 1'b1) begin bad++; $display("FAIL stall_resume_rr got %b want 1", read_request); end
    total++; if (instructionAddress !== 64'h10) begin bad++; $display("FAIL stall_resume_addr got %h want 10", instructionAddress); end
  endtask

  task automatic test_branch_wait();
    readReady = 1'b1;
    restart();
    step(); step(); step(); step();
    total++; if (instructionAddress !== 64'h8) begin bad++; $display("FAIL br_pre_addr got %h want 8", instructionAddress); end
    branch_taken  = 1'b1;
    branch_target = 64'h13;
    step();
    branch_taken = 1'b0;
    total++; if (instructionAddress !== 64'h10) begin bad++; $display("FAIL br_addr got %h want 10", instructionAddress); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL br_fv got %b want 0", fetch_valid); end
    step();
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL br_wait_fv got %b want 0", fetch_valid); end
    step();
    total++; if (fetch_pc !== 64'h10) begin bad++; $display("FAIL br_fpc got %h want 10", fetch_pc); end
    total++; if (fetch_instruction !== mem_word(64'h10)) begin bad++; $display("FAIL br_fi got %h want %h", fetch_instruction, mem_word(64'h10)); end
    branch_taken  = 1'b1;
    branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
    step();
    branch_taken = 1'b0;
    total++; if (instructionAddress !== 64'hFFFF_FFFF_FFFF_FFF8) begin bad++; $display("FAIL wrap_addr got %h want fffffffffffffff8", instructionAddress); end
    step(); step();
    total++; if (fetch_pc !== 64'hFFFF_FFFF_FFFF_FFF8) begin bad++; $display("FAIL wrap_fpc got %h want fffffffffffffff8", fetch_pc); end
    step();
    total++; if (instructionAddress !== 64'h0) begin bad++; $display("FAIL wrap_next_addr got %h want 0", instructionAddress); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL wrap_done got %b want 0", done); end
  endtask

  task automatic test_branch_stall();
    readReady = 1'b1;
    restart();
    step(); step();
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 64'h20;
    step();
    stall        = 1'b0;
    branch_taken = 1'b0;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL brst_fv got %b want 0", fetch_valid); end
    total++; if (instructionAddress !== 64'h20) begin bad++; $display("FAIL brst_addr got %h want 20", instructionAddress); end
    step(); step();
    total++; if (fetch_pc !== 64'h20) begin bad++; $display("FAIL brst_fpc got %h want 20", fetch_pc); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL last_done got %b want 1", done); end
    branch_taken  = 1'b1;
    branch_target = 64'h8;
    step();
    branch_taken = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL done_br_done got %b want 0", done); end
    total++; if (instructionAddress !== 64'h8) begin bad++; $display("FAIL done_br_addr got %h want 8", instructionAddress); end
  endtask

  task automatic test_prefetch();
    readReady = 1'b1;
    stall     = 1'b1;
    restart();
    step();
    step();
    total++; if (fetch_valid !== 1'b1) begin bad++; $display("FAIL pf_fv1 got %b want 1", fetch_valid); end
    total++; if (fetch_pc !== 64'h0) begin bad++; $display("FAIL pf_fpc1 got %h want 0", fetch_pc); end
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      total++; if (read_request !== 1'b0) begin bad++; $display("FAIL pf_full_rr i=%0d got %b want 0", i, read_request); end
      total++; if (fetch_pc !== 64'h0) begin bad++; $display("FAIL pf_full_fpc i=%0d got %h want 0", i, fetch_pc); end
      step();
    end
    branch_taken  = 1'b1;
    branch_target = 64'h0;
    step();
    branch_taken = 1'b0;
    stall        = 1'b0;
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL pf_flush_fv got %b want 0", fetch_valid); end
    total++; if (read_request !== 1'b1) begin bad++; $display("FAIL pf_flush_rr got %b want 1", read_request); end
  endtask

  task automatic test_async_reset();
    readReady = 1'b0;
    restart();
    branch_taken  = 1'b1;
    branch_target = 64'h18;
    step();
    branch_taken = 1'b0;
    step();
    total++; if (instructionAddress !== 64'h18) begin bad++; $display("FAIL ar_pre_addr got %h want 18", instructionAddress); end
    total++; if (read_request !== 1'b1) begin bad++; $display("FAIL ar_pre_rr got %b want 1", read_request); end
    #2;
    reset = 1'b0;
    #1;
    total++; if (read_request !== 1'b0) begin bad++; $display("FAIL ar_rr got %b want 0", read_request); end
    total++; if (instructionAddress !== 64'h0) begin bad++; $display("FAIL ar_addr got %h want 0", instructionAddress); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL ar_fv got %b want 0", fetch_valid); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL ar_done got %b want 0", done); end
    step();
    reset     = 1'b1;
    readReady = 1'b1;
    step(); step(); step();
    total++; if (read_request !== 1'b0) begin bad++; $display("FAIL ar_idle_rr got %b want 0", read_request); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("FAIL ar_idle_fv got %b want 0", fetch_valid); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (instructionAddress !== 64'h0) begin bad++; $display("FAIL ar_start_addr got %h want 0", instructionAddress); end
    total++; if (read_request !== 1'b1) begin bad++; $display("FAIL ar_start_rr got %b want 1", read_request); end
  endtask

  initial begin
    reset         = 1'b0;
    start         = 1'b0;
    readReady     = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 64'h0;
    stall         = 1'b0;
    test_reset();
`ifdef PREFETCH_BUF_EN
    test_prefetch();
`else
    test_sequential();
    test_stall();
    test_branch_wait();
    test_branch_stall();
`endif
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
